// File: rtl/cla_multiword_adder_if.sv
// Operand request / result handshake bundle for cla_multiword_adder.
// The ovf signal exists only when OVERFLOW_FLAG_EN is defined.
interface cla_multiword_adder_if #(
  parameter int unsigned N     = 4,
  parameter int unsigned WORDS = 4
);
  localparam int unsigned W = N * WORDS;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         sum_valid;
  logic         sum_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         busy;
`ifdef OVERFLOW_FLAG_EN
  logic         ovf;
`endif

  modport master (
`ifdef OVERFLOW_FLAG_EN
    input  ovf,
`endif
    output in_valid, a, b, cin, sum_ready,
    input  in_ready, sum_valid, sum, cout, busy
  );

  modport slave (
`ifdef OVERFLOW_FLAG_EN
    output ovf,
`endif
    input  in_valid, a, b, cin, sum_ready,
    output in_ready, sum_valid, sum, cout, busy
  );
endinterface

// File: rtl/cla_multiword_adder.sv
// Multi-precision adder: one N-bit carry-lookahead slice per clock, LSB slice first.
// Optional macro OVERFLOW_FLAG_EN adds a registered two's-complement overflow output.
module cla_multiword_adder #(
  parameter int unsigned N     = 4,
  parameter int unsigned WORDS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  cla_multiword_adder_if.slave  bus
);
  localparam int unsigned W  = N * WORDS;
  localparam int unsigned IW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IW-1:0] LAST = IW'(WORDS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [W-1:0]    a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic            carry_q, carry_d, cout_q, cout_d;
  logic            in_ready_q, in_ready_d, sum_valid_q, sum_valid_d, busy_q, busy_d;
`ifdef OVERFLOW_FLAG_EN
  logic            ovf_q, ovf_d;
`endif

  logic [N-1:0]    a_sl, b_sl, g, p, s;
  logic [N:0]      c;
  logic            prod, cc;

  // Current slice selection and flattened lookahead carries from the carry register
  always_comb begin
    a_sl = '0;
    b_sl = '0;
    for (int k = 0; k < int'(WORDS); k++) begin
      if (idx_q == IW'(k)) begin
        a_sl = a_q[k*N +: N];
        b_sl = b_q[k*N +: N];
      end
    end
    g    = a_sl & b_sl;
    p    = a_sl ^ b_sl;
    c    = '0;
    c[0] = carry_q;
    prod = 1'b0;
    cc   = 1'b0;
    for (int i = 0; i < int'(N); i++) begin
      cc = 1'b0;
      for (int j = 0; j <= i; j++) begin
        prod = g[j];
        for (int m = j + 1; m <= i; m++) prod = prod & p[m];
        cc = cc | prod;
      end
      prod = carry_q;
      for (int m = 0; m <= i; m++) prod = prod & p[m];
      c[i+1] = cc | prod;
    end
    s = p ^ c[N-1:0];
  end

  // Next-state and next register values
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
`ifdef OVERFLOW_FLAG_EN
    ovf_d   = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.in_valid && in_ready_q) begin
          a_d     = bus.a;
          b_d     = bus.b;
          carry_d = bus.cin;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        for (int k = 0; k < int'(WORDS); k++) begin
          if (idx_q == IW'(k)) sum_d[k*N +: N] = s;
        end
        carry_d = c[N];
        if (idx_q == LAST) begin
          cout_d  = c[N];
`ifdef OVERFLOW_FLAG_EN
          ovf_d   = c[N-1] ^ c[N];
`endif
          state_d = DONE;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      DONE: begin
        if (bus.sum_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    in_ready_d  = (state_d == IDLE);
    sum_valid_d = (state_d == DONE);
    busy_d      = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      carry_q     <= 1'b0;
      cout_q      <= 1'b0;
      in_ready_q  <= 1'b1;
      sum_valid_q <= 1'b0;
      busy_q      <= 1'b0;
`ifdef OVERFLOW_FLAG_EN
      ovf_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      a_q         <= a_d;
      b_q         <= b_d;
      sum_q       <= sum_d;
      carry_q     <= carry_d;
      cout_q      <= cout_d;
      in_ready_q  <= in_ready_d;
      sum_valid_q <= sum_valid_d;
      busy_q      <= busy_d;
`ifdef OVERFLOW_FLAG_EN
      ovf_q       <= ovf_d;
`endif
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.sum_valid = sum_valid_q;
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
  assign bus.busy      = busy_q;
`ifdef OVERFLOW_FLAG_EN
  assign bus.ovf       = ovf_q;
`endif

endmodule

// File: doc/cla_multiword_adder.md
Name: cla_multiword_adder

Overview:
Multi-precision adder sequencer built around an N-bit carry-lookahead slice. It captures two W-bit operands, where W = N*WORDS. It then adds them one N-bit slice per clock, least-significant slice first, holding the inter-slice carry in a register. The block sits in front of the result path and presents the full W-bit sum and carry-out through a valid/ready handshake.

Parameters:
N, 4, slice width in bits; internal generate/propagate lookahead width per cycle.
WORDS, 4, number of slices; W = N*WORDS (default 16). WORDS >= 1.

Ports:
clk  input  1  clock; all state changes on the rising edge.
rst  input  1  asynchronous, active-high reset.
in_valid  input  1  operand request.
in_ready  output  1  high only in IDLE.
a  input  W  operand A, captured on the accept edge.
b  input  W  operand B, captured on the accept edge.
cin  input  1  carry into slice 0, captured on the accept edge.
sum_valid  output  1  result valid; high only in DONE.
sum_ready  input  1  result consumer ready.
sum  output  W  registered sum.
cout  output  1  registered carry out of the MSB.
busy  output  1  high in RUN or DONE.

Behaviour:
- Reset (asynchronous, any state): state=IDLE, slice index idx=0, sum=0, cout=0, carry register=0, operand registers=0, sum_valid=0, busy=0, in_ready=1.
- States are IDLE, RUN and DONE, with a 2-bit encoding.
- IDLE: in_ready=1. On in_valid&in_ready:
  - capture a, b and cin (cin goes into the carry register);
  - set idx=0;
  - go to RUN.
- RUN, one slice per cycle, slice k = bits [k*N +: N]:
  - Per bit: G=a&b, P=a^b.
  - c[0]=carry register; c[i+1]=G[i]|(P[i]&c[i]); s[i]=P[i]^c[i].
  - On each edge, write s into sum slice idx and write c[N] into the carry register.
  - If idx==WORDS-1: cout<=c[N] and go to DONE. Otherwise idx<=idx+1.
- Latency: sum_valid rises exactly WORDS cycles after the accept edge (4 cycles at default).
- Sum slices not yet processed hold their prior value. Only the value presented while sum_valid=1 is defined.
- DONE: sum_valid=1, and sum and cout are held stable.
  - On sum_valid&sum_ready: go to IDLE and drop sum_valid. sum and cout keep their values.
  - in_ready asserts in the cycle after the handshake; there is no same-cycle re-accept.
- in_valid while in RUN or DONE is ignored; no request is queued.
- Input operands need not be held after the accept edge.
- Width rules:
  - idx is clog2(WORDS) bits, minimum 1.
  - Arithmetic is unsigned modulo 2^W; carry out is reported in cout.
- WORDS=1: RUN lasts one cycle, so sum_valid rises one cycle after accept.
- Reset asserted mid-RUN or mid-DONE aborts the operation; no partial result is presented.

Optional Feature:
Macro OVERFLOW_FLAG_EN.
- Defined: adds output port ovf (1 bit), which is the two's-complement overflow of the W-bit add.
  - ovf is registered on the final RUN edge as carry-into-MSB XOR carry-out-of-MSB.
  - Valid with sum_valid; reset value 0; held through DONE.
- Undefined: no ovf port and no extra logic. All other behaviour is identical.

Test Plan:
1. a=0xFFFF, b=0x0001, cin=0, sum_ready=1 -> sum_valid high exactly 4 cycles after accept; sum=0x0000, cout=1; ovf=0 if enabled.
2. a=0x1234, b=0x4321, cin=0 -> sum=0x5555, cout=0. With cin=1 instead -> sum=0x5556, cout=0.
3. a=0x7FFF, b=0x0000, cin=1 -> sum=0x8000, cout=0; ovf=1 with OVERFLOW_FLAG_EN.
4. Backpressure: hold sum_ready=0 for 3 cycles after sum_valid with a=0x00FF, b=0x0F0F:
   - sum=0x100E, and sum/cout stay stable while held;
   - in_valid pulsed during RUN and DONE is ignored and in_ready stays 0;
   - after sum_ready=1, in_ready=1 on the next cycle.
5. Reset mid-RUN: assert rst 2 cycles after accept -> immediately sum_valid=0, sum=0, in_ready=1. The next op 0x0001+0x0001 yields 0x0002.
6. Back-to-back: keep in_valid=1 with new operands each time in_ready is high, 3 ops -> each result matches the golden (a+b+cin) mod 2^16 and its carry. Accept-to-accept period is WORDS+2 cycles.
